// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction
//   fetch path and the load/store path. Accesses are serialized. Data has
//   priority over fetch, but the fetch is forced through after MAX_WAIT
//   consecutive data wins while it was waiting.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   if_req/if_addr       fetch request (held until if_done)
//   if_done/if_rdata     fetch completion pulse and registered instruction
//   if_stall             if_req & ~if_done
//   d_req/d_we/d_addr/d_wdata/d_wmask   load/store request (held until d_done)
//   d_done/d_rdata       data completion pulse and registered load data
//   d_stall              d_req & ~d_done
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask   memory access, registered
//   mem_rdata            read data, valid LATENCY cycles after mem_req
module mem_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int LATENCY  = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              win_d_q, win_d_d;   // 1: current access belongs to data path
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;

    // Data wins unless the fetch has already been passed over MAX_WAIT times.
    assign grant_data = d_req && (!if_req || (wait_q < WW'(MAX_WAIT)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        win_d_d     = win_d_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    win_d_d   = grant_data;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                    if (grant_data) begin
                        // Only a data win over a waiting fetch counts toward starvation.
                        if (if_req) wait_d = wait_q + WW'(1);
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wmask_d = d_we ? d_wmask : 4'b0000;
                    end else begin
                        // Fetches carry no write data; wdata is zeroed.
                        wait_d      = '0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = 4'b0000;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(LATENCY)) begin
                    state_d = RESP;
                    if (win_d_q) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                // Done pulse is visible this cycle; requester drops or replaces
                // its request at this edge, so no arbitration here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            win_d_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 4'b0000;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            win_d_q     <= win_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_done_q;
    assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction-level reference model with a
// per-cycle compare process, directed literal pins, then random traffic.
// A second instance built with LATENCY=1 gets a directed fetch check.
module tb_mem_port_arbiter;
    localparam int L  = 2;
    localparam int MW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_wmask = 0;
    logic        if_done, if_stall, d_done, d_stall, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    logic        b_if_req = 0;
    logic [31:0] b_if_addr = 0, b_mem_rdata = 0;
    logic        b_if_done, b_if_stall, b_d_done, b_d_stall, b_mem_req, b_mem_we;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wmask;

    mem_port_arbiter #(.DATA_W(32), .LATENCY(L), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.DATA_W(32), .LATENCY(1), .MAX_WAIT(MW)) dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_wmask(4'h0),
        .d_done(b_d_done), .d_rdata(b_d_rdata), .d_stall(b_d_stall),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    int n_pass = 0, n_chk = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Memory contents: two fixed words used by the directed tests, a hash elsewhere.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h00500093;
            32'h200: return 32'h12345678;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    // Reference model: per access, the grant cycle g (mem_req cycle) fixes
    // done at g+L+1 and the next arbitration edge at the end of cycle g+L+2.
    int          gcyc, next_arb, wc;
    logic        e_win_d, e_mem_req, e_mem_we, e_if_done, e_d_done;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
    logic [3:0]  e_mem_wmask;

    task automatic model_reset();
        gcyc = -1000; next_arb = cyc; wc = 0; e_win_d = 0;
        e_mem_req = 0; e_mem_we = 0; e_if_done = 0; e_d_done = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_mem_wmask = 0; e_if_rdata = 0; e_d_rdata = 0;
    endtask

    task automatic model_step(input logic s_if, input logic s_d, input logic s_we,
                              input logic [31:0] s_ia, input logic [31:0] s_da,
                              input logic [31:0] s_wd, input logic [3:0] s_wm);
        bit data_wins;
        e_mem_req = 0; e_if_done = 0; e_d_done = 0;
        if (cyc == gcyc + L + 1) begin
            if (e_win_d) begin
                e_d_done = 1;
                if (!e_mem_we) e_d_rdata = mem_val(e_mem_addr);
            end else begin
                e_if_done  = 1;
                e_if_rdata = mem_val(e_mem_addr);
            end
        end
        if (cyc - 1 >= next_arb && (s_if || s_d)) begin
            data_wins = s_d && !(s_if && wc == MW);
            if (s_if) wc = data_wins ? wc + 1 : 0;
            e_win_d     = data_wins;
            e_mem_we    = data_wins ? s_we : 1'b0;
            e_mem_addr  = data_wins ? s_da : s_ia;
            e_mem_wdata = data_wins ? s_wd : 32'h0;
            e_mem_wmask = (data_wins && s_we) ? s_wm : 4'h0;
            e_mem_req   = 1;
            gcyc        = cyc;
            next_arb    = cyc + L + 2;
        end
    endtask

    // Memory behaviour follows the DUT's own mem_req, so a misplaced strobe
    // shows up as wrong data or timing against the model.
    int          due = -1, b_due = -1;
    logic [31:0] due_addr = 0, b_due_addr = 0;
    logic        dut_grants[$];

    task automatic step();
        logic s_rst, s_if, s_d, s_we;
        logic [31:0] s_ia, s_da, s_wd;
        logic [3:0] s_wm;
        s_rst = reset; s_if = if_req; s_d = d_req; s_we = d_we;
        s_ia = if_addr; s_da = d_addr; s_wd = d_wdata; s_wm = d_wmask;
        @(posedge clk);
        cyc++;
        #1;
        if (s_rst || reset) model_reset();
        else model_step(s_if, s_d, s_we, s_ia, s_da, s_wd, s_wm);
        mem_rdata   = (cyc == due)   ? mem_val(due_addr)   : $urandom;
        b_mem_rdata = (cyc == b_due) ? mem_val(b_due_addr) : $urandom;
        if (mem_req)   begin due = cyc + L; due_addr = mem_addr; dut_grants.push_back(mem_we); end
        if (b_mem_req) begin b_due = cyc + 1; b_due_addr = b_mem_addr; end
    endtask

    always @(negedge clk) begin
        chk("mem_req",   {31'b0, mem_req},  {31'b0, e_mem_req});
        chk("mem_we",    {31'b0, mem_we},   {31'b0, e_mem_we});
        chk("mem_addr",  mem_addr,          e_mem_addr);
        chk("mem_wdata", mem_wdata,         e_mem_wdata);
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_mem_wmask});
        chk("if_done",   {31'b0, if_done},  {31'b0, e_if_done});
        chk("d_done",    {31'b0, d_done},   {31'b0, e_d_done});
        chk("if_rdata",  if_rdata,          e_if_rdata);
        chk("d_rdata",   d_rdata,           e_d_rdata);
        chk("if_stall",  {31'b0, if_stall}, {31'b0, if_req & ~e_if_done});
        chk("d_stall",   {31'b0, d_stall},  {31'b0, d_req & ~e_d_done});
    end

    // Single fetch on the main DUT with literal timing pins (request in cycle 0).
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_data);
        if_req = 1; if_addr = a;
        step();
        chk("f_c1_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("f_c1_mem_we",   {31'b0, mem_we},  32'd0);
        chk("f_c1_mem_addr", mem_addr, a);
        chk("f_c1_stall",    {31'b0, if_stall}, 32'd1);
        step(); step();
        chk("f_c3_if_done",  {31'b0, if_done}, 32'd0);
        step();
        chk("f_c4_if_done",  {31'b0, if_done}, 32'd1);
        chk("f_c4_if_rdata", if_rdata, exp_data);
        if_req = 0;
        step(); step();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_done",   {31'b0, d_done}, 32'd0);
        step(); step();
        reset = 0;
        step();

        // Single fetch; the LATENCY=1 instance runs the same fetch alongside.
        b_if_req = 1; b_if_addr = 32'h40;
        if_req = 1; if_addr = 32'h40;
        step();
        chk("f_c1_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("f_c1_mem_addr", mem_addr, 32'h40);
        chk("l1_c1_mem_req", {31'b0, b_mem_req}, 32'd1);
        step();
        chk("l1_c2_if_done", {31'b0, b_if_done}, 32'd0);
        step();
        chk("l1_c3_if_done",  {31'b0, b_if_done}, 32'd1);
        chk("l1_c3_if_rdata", b_if_rdata, 32'h00500093);
        chk("l1_c3_d_done",   {31'b0, b_d_done}, 32'd0);
        b_if_req = 0;
        step();
        chk("f_c4_if_done",  {31'b0, if_done}, 32'd1);
        chk("f_c4_if_rdata", if_rdata, 32'h00500093);
        if_req = 0;
        step(); step();

        // Load: mask forced to 0, only d_rdata updates.
        d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = 32'hCAFEF00D; d_wmask = 4'hF;
        step();
        chk("ld_c1_mem_wmask", {28'b0, mem_wmask}, 32'd0);
        chk("ld_c1_mem_addr",  mem_addr, 32'h200);
        step(); step(); step();
        chk("ld_c4_d_done",   {31'b0, d_done}, 32'd1);
        chk("ld_c4_d_rdata",  d_rdata, 32'h12345678);
        chk("ld_c4_if_rdata", if_rdata, 32'h00500093);
        d_req = 0;
        step(); step();

        // Simultaneous store and fetch: store first, fetch follows.
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
        if_req = 1; if_addr = 32'h44;
        step();
        chk("sim_c1_mem_we",    {31'b0, mem_we}, 32'd1);
        chk("sim_c1_mem_wmask", {28'b0, mem_wmask}, 32'hF);
        chk("sim_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step(); step(); step();
        chk("sim_c4_d_done", {31'b0, d_done}, 32'd1);
        d_req = 0;
        step(); step();
        chk("sim_c6_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("sim_c6_mem_addr", mem_addr, 32'h44);
        step(); step(); step();
        chk("sim_c9_if_done", {31'b0, if_done}, 32'd1);
        chk("sim_c9_d_rdata", d_rdata, 32'h12345678);
        if_req = 0;
        step(); step();

        // Asynchronous reset in the middle of a fetch access.
        if_req = 1; if_addr = 32'h48;
        step(); step();
        #2 reset = 1;
        #1;
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_d_rdata",  d_rdata, 32'd0);
        chk("arst_mem_we",   {31'b0, mem_we}, 32'd0);
        model_reset();
        if_req = 0;
        #2 reset = 0;
        step(); step();
        chk("arst_late_no_done", {31'b0, if_done}, 32'd0);
        do_fetch(32'h40, 32'h00500093);

        // Starvation: both requesters always busy, replaced on their done.
        dut_grants.delete();
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1; d_wmask = 4'h3;
        for (int i = 0; i < 39; i++) begin
            step();
            if (e_d_done) begin d_addr += 4; d_wdata += 1; end
            if (e_if_done) if_addr += 4;
        end
        if_req = 0;
        chk("starve_grants", dut_grants.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic exp_we;
            exp_we = (i % 4 != 3);
            if (i < dut_grants.size()) chk($sformatf("starve_grant%0d", i), {31'b0, dut_grants[i]}, {31'b0, exp_we});
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (e_if_done || !if_req) begin
                if ($urandom_range(99) < 45) begin if_req = 1; if_addr = $urandom & 32'hFFFC; end
                else if_req = 0;
            end
            if (e_d_done || !d_req) begin
                if ($urandom_range(99) < 55) begin
                    d_req = 1; d_we = $urandom_range(1); d_addr = $urandom & 32'hFFFC;
                    d_wdata = $urandom; d_wmask = 4'($urandom);
                end else d_req = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
